// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter between NUM_REQ byte-stream requesters.
// Grants are round-robin at packet granularity: once a requester owns the
// transmitter it keeps it until its byte flagged req_last has left the line.
// Each byte is started with a one-clock uart_transmit pulse. If the UART does
// not raise uart_is_transmitting within START_TIMEOUT clocks, the start is
// retried with the same byte. GAP_CYCLES idle clocks follow every byte.
//
// Handshake: requester i's byte moves when req_valid[i] and req_ready[i] are
// both high at a rising clk edge. req_ready is raised only for the current
// owner while in LOAD and never depends on req_valid, so a requester may hold
// valid/data/last steady and simply wait for that edge.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int GAP_CYCLES    = 0,
    parameter int START_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   uart_transmit,
    output logic [7:0]             uart_tx_byte,
    input  logic                   uart_is_transmitting,
    output logic                   busy,
    output logic                   tx_timeout,
    output logic [2:0]             state_dbg
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TO_W  = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((START_TIMEOUT > 1) ? START_TIMEOUT - 1 : 0);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD       = 3'd1,
        S_KICK       = 3'd2,
        S_WAIT_START = 3'd3,
        S_WAIT_DONE  = 3'd4,
        S_GAP        = 3'd5
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   last_ptr;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   cand;
    logic               pick_found;
    logic [NUM_REQ-1:0] pick_onehot;
    logic               last_q;
    logic [TO_W-1:0]    to_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               xfer;
    logic               timeout_hit;
    logic               pkt_done;
    logic [7:0]         owner_byte;
    logic               owner_last;

    // Byte and last flag presented by the current owner.
    assign owner_byte = req_data[{owner, 3'b000} +: 8];
    assign owner_last = req_last[owner];

    // Only the owner is offered ready, and only while waiting for its next byte.
    assign req_ready  = (state == S_LOAD) ? grant : '0;
    assign xfer       = (state == S_LOAD) && (|(grant & req_valid));
    assign state_dbg  = state;

    // Round-robin pick: first valid requester after last_ptr, searching cyclically.
    always_comb begin
        pick_found  = 1'b0;
        pick_idx    = '0;
        cand        = '0;
        pick_onehot = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = PTR_W'((int'(last_ptr) + k) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
        pick_onehot[pick_idx] = 1'b1;
    end

    // Next-state decode and the one-clock events derived from it.
    always_comb begin
        state_n     = state;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (pick_found) state_n = S_LOAD;
            end
            S_LOAD: begin
                if (xfer) state_n = S_KICK;
            end
            S_KICK: begin
                state_n = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (uart_is_transmitting) begin
                    state_n = S_WAIT_DONE;
                end else if (to_cnt == TO_LAST) begin
                    state_n     = S_KICK;
                    timeout_hit = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!uart_is_transmitting) begin
                    if (GAP_CYCLES > 0) state_n = S_GAP;
                    else                state_n = last_q ? S_IDLE : S_LOAD;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) state_n = last_q ? S_IDLE : S_LOAD;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        pkt_done = (state != S_IDLE) && (state_n == S_IDLE);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    // Grant, byte latch, counters and registered strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant         <= '0;
            owner         <= '0;
            last_ptr      <= PTR_INIT;
            last_q        <= 1'b0;
            to_cnt        <= '0;
            gap_cnt       <= '0;
            uart_tx_byte  <= 8'h00;
            uart_transmit <= 1'b0;
            tx_timeout    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            uart_transmit <= (state == S_KICK);
            tx_timeout    <= timeout_hit;
            busy          <= (state_n != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        grant <= pick_onehot;
                        owner <= pick_idx;
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        uart_tx_byte <= owner_byte;
                        last_q       <= owner_last;
                    end
                end
                S_KICK: begin
                    to_cnt <= '0;
                end
                S_WAIT_START: begin
                    if (!uart_is_transmitting && to_cnt != TO_LAST) to_cnt <= to_cnt + 1'b1;
                end
                S_WAIT_DONE: begin
                    gap_cnt <= '0;
                end
                S_GAP: begin
                    if (gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + 1'b1;
                end
                default: begin
                end
            endcase
            if (pkt_done) begin
                grant    <= '0;
                last_ptr <= owner;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Two arbiters side by side: chan 0 with GAP_CYCLES=0, chan 1 with
// GAP_CYCLES=5, both START_TIMEOUT=16. Each has a small UART stand-in that
// accepts a start pulse, reports busy for TX_LEN clocks and records the byte.
module tb_uart_tx_arbiter;

  localparam int TX_LEN = 8;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_KICK = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [3:0]  req_valid [2];
  logic [31:0] req_data [2];
  logic [3:0]  req_last [2];
  logic [3:0]  req_ready [2];
  logic [3:0]  grant [2];
  logic [7:0]  uart_tx_byte [2];
  logic [2:0]  state_dbg [2];
  logic [1:0]  uart_transmit;
  logic [1:0]  uart_is_tx;
  logic [1:0]  busy;
  logic [1:0]  tx_timeout;

  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(0), .START_TIMEOUT(16)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_data(req_data[0]), .req_last(req_last[0]),
    .req_ready(req_ready[0]), .grant(grant[0]),
    .uart_transmit(uart_transmit[0]), .uart_tx_byte(uart_tx_byte[0]),
    .uart_is_transmitting(uart_is_tx[0]),
    .busy(busy[0]), .tx_timeout(tx_timeout[0]), .state_dbg(state_dbg[0])
  );

  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(5), .START_TIMEOUT(16)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_data(req_data[1]), .req_last(req_last[1]),
    .req_ready(req_ready[1]), .grant(grant[1]),
    .uart_transmit(uart_transmit[1]), .uart_tx_byte(uart_tx_byte[1]),
    .uart_is_transmitting(uart_is_tx[1]),
    .busy(busy[1]), .tx_timeout(tx_timeout[1]), .state_dbg(state_dbg[1])
  );

  // ---------------- UART stand-in ----------------
  logic [3:0] mdl_cnt [2];
  logic [1:0] stuck = 2'b00;
  logic [7:0] rx0_q [$];
  logic [7:0] rx1_q [$];

  assign uart_is_tx = {mdl_cnt[1] != 4'd0, mdl_cnt[0] != 4'd0};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdl_cnt[0] <= 4'd0;
      mdl_cnt[1] <= 4'd0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (mdl_cnt[c] != 4'd0) begin
          mdl_cnt[c] <= mdl_cnt[c] - 4'd1;
        end else if (uart_transmit[c] && !stuck[c]) begin
          mdl_cnt[c] <= 4'(TX_LEN);
          if (c == 0) rx0_q.push_back(uart_tx_byte[c]);
          else        rx1_q.push_back(uart_tx_byte[c]);
        end
      end
    end
  end

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [8:0] src_mem [8][32];
  int src_wr [8];
  int src_rd [8];
  logic [7:0] hold = 8'h00;
  logic [3:0] prev_grant [2];
  logic [3:0] prev_ready [2];
  logic [1:0] prev_is_tx;
  int fall_cyc [2];
  logic [3:0] glog0_q [$];
  logic [3:0] glog1_q [$];
  int gap0_q [$];
  int gap1_q [$];
  int to_cyc_q [$];
  int tx_cyc_q [$];
  logic [7:0] txb_q [$];
  logic [7:0] exp_q [$];
  logic [3:0] exp_g [$];

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // ---------------- drivers ----------------
  task automatic push_byte(input int c, input int i, input logic [7:0] d, input logic last);
    int k;
    k = c * 4 + i;
    src_mem[k][src_wr[k]] = {last, d};
    src_wr[k]++;
  endtask

  task automatic refresh();
    int k;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 4; i++) begin
        k = c * 4 + i;
        if (src_rd[k] != src_wr[k] && !hold[k]) begin
          req_valid[c][i]       = 1'b1;
          req_data[c][8*i +: 8] = src_mem[k][src_rd[k]][7:0];
          req_last[c][i]        = src_mem[k][src_rd[k]][8];
        end else begin
          req_valid[c][i]       = 1'b0;
          req_data[c][8*i +: 8] = 8'h00;
          req_last[c][i]        = 1'b0;
        end
      end
    end
  endtask

  // One clock: sample on the falling edge, retire accepted bytes after the rising edge.
  task automatic step();
    logic [3:0] fire [2];
    @(negedge clk);
    cyc++;
    for (int c = 0; c < 2; c++) begin
      fire[c] = req_valid[c] & req_ready[c];
      if (grant[c] != 4'd0 && grant[c] != prev_grant[c]) begin
        if (c == 0) glog0_q.push_back(grant[c]);
        else        glog1_q.push_back(grant[c]);
      end
      if (prev_is_tx[c] && !uart_is_tx[c]) fall_cyc[c] = cyc;
      if (req_ready[c] != 4'd0 && prev_ready[c] == 4'd0 && fall_cyc[c] >= 0) begin
        if (c == 0) gap0_q.push_back(cyc - fall_cyc[c]);
        else        gap1_q.push_back(cyc - fall_cyc[c]);
      end
      prev_grant[c] = grant[c];
      prev_ready[c] = req_ready[c];
      prev_is_tx[c] = uart_is_tx[c];
    end
    if (tx_timeout[0]) begin
      to_cyc_q.push_back(cyc);
      check("timeout_in_kick", state_dbg[0], ST_KICK);
    end
    if (uart_transmit[0]) begin
      tx_cyc_q.push_back(cyc);
      txb_q.push_back(uart_tx_byte[0]);
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 4; i++)
        if (fire[c][i]) src_rd[c * 4 + i]++;
    refresh();
  endtask

  function automatic bit chan_idle(input int c);
    for (int i = 0; i < 4; i++)
      if (src_rd[c * 4 + i] != src_wr[c * 4 + i]) return 1'b0;
    return !busy[c] && !uart_is_tx[c];
  endfunction

  task automatic wait_idle(input int c, input int budget, input string tag);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      step();
      done = chan_idle(c);
    end
    check({tag, "_idle"}, done, 1);
  endtask

  task automatic clear_logs();
    glog0_q.delete(); glog1_q.delete();
    gap0_q.delete(); gap1_q.delete();
    to_cyc_q.delete(); tx_cyc_q.delete(); txb_q.delete();
    fall_cyc[0] = -1;
    fall_cyc[1] = -1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) src_rd[k] = src_wr[k];
    hold = 8'h00;
    refresh();
    repeat (3) step();
    rst = 1'b1;
    step();
    rx0_q.delete();
    rx1_q.delete();
    clear_logs();
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_rx(input int c, input string tag);
    logic [7:0] got_q [$];
    logic [31:0] g;
    logic [7:0] e;
    if (c == 0) begin got_q = rx0_q; rx0_q.delete(); end
    else        begin got_q = rx1_q; rx1_q.delete(); end
    check({tag, "_rx_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? {24'd0, got_q.pop_front()} : 32'hFFFF_FFFF;
      check({tag, "_rx_byte"}, g, {24'd0, e});
    end
  endtask

  task automatic check_glog(input int c, input string tag);
    logic [3:0] got_q [$];
    logic [31:0] g;
    logic [3:0] e;
    if (c == 0) begin got_q = glog0_q; glog0_q.delete(); end
    else        begin got_q = glog1_q; glog1_q.delete(); end
    check({tag, "_grant_count"}, got_q.size(), exp_g.size());
    while (exp_g.size() > 0) begin
      e = exp_g.pop_front();
      g = (got_q.size() > 0) ? {28'd0, got_q.pop_front()} : 32'hFFFF_FFFF;
      check({tag, "_grant"}, g, {28'd0, e});
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected fewer", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed tests ----------------
  initial begin
    bit hit;
    for (int k = 0; k < 8; k++) begin src_wr[k] = 0; src_rd[k] = 0; end
    for (int c = 0; c < 2; c++) begin
      prev_grant[c] = 4'd0; prev_ready[c] = 4'd0; fall_cyc[c] = -1;
    end
    prev_is_tx = 2'b00;
    refresh();

    // Reset values
    repeat (3) step();
    check("rst_grant", grant[0], 4'h0);
    check("rst_req_ready", req_ready[0], 4'h0);
    check("rst_transmit", uart_transmit[0], 1'b0);
    check("rst_tx_byte", uart_tx_byte[0], 8'h00);
    check("rst_busy", busy[0], 1'b0);
    check("rst_tx_timeout", tx_timeout[0], 1'b0);
    rst = 1'b1;
    step();

    // Single byte with start latency
    push_byte(0, 0, 8'h55, 1'b1);
    refresh();
    step();
    check("sb_grant", grant[0], 4'b0001);
    check("sb_req_ready", req_ready[0], 4'b0001);
    check("sb_busy", busy[0], 1'b1);
    step();
    check("sb_state_kick", state_dbg[0], ST_KICK);
    check("sb_transmit_early", uart_transmit[0], 1'b0);
    check("sb_tx_byte", uart_tx_byte[0], 8'h55);
    check("sb_ready_dropped", req_ready[0], 4'b0000);
    step();
    check("sb_transmit", uart_transmit[0], 1'b1);
    step();
    check("sb_transmit_pulse", uart_transmit[0], 1'b0);
    wait_idle(0, 100, "sb");
    exp_q.push_back(8'h55);
    check_rx(0, "sb");
    check("sb_grant_end", grant[0], 4'h0);
    check("sb_busy_end", busy[0], 1'b0);
    check("sb_state_end", state_dbg[0], ST_IDLE);
    check("sb_kicks", tx_cyc_q.size(), 1);

    // Round-robin, twice
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      push_byte(0, 0, 8'hA0, 1'b1);
      push_byte(0, 1, 8'hA1, 1'b1);
      push_byte(0, 2, 8'hA2, 1'b1);
      push_byte(0, 3, 8'hA3, 1'b1);
      refresh();
      wait_idle(0, 300, "rr");
      exp_g.push_back(4'b0001); exp_g.push_back(4'b0010);
      exp_g.push_back(4'b0100); exp_g.push_back(4'b1000);
      check_glog(0, "rr");
      exp_q.push_back(8'hA0); exp_q.push_back(8'hA1);
      exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
      check_rx(0, "rr");
    end

    // Packet lock: requester 1 pauses mid-packet while requester 2 waits
    clear_logs();
    push_byte(0, 1, 8'h11, 1'b0);
    push_byte(0, 2, 8'h44, 1'b1);
    refresh();
    for (int n = 0; n < 20 && src_rd[1] != src_wr[1]; n++) step();
    hold[1] = 1'b1;
    push_byte(0, 1, 8'h22, 1'b0);
    push_byte(0, 1, 8'h33, 1'b1);
    refresh();
    repeat (20) step();
    check("lock_grant_held", grant[0], 4'b0010);
    check("lock_ready_owner", req_ready[0], 4'b0010);
    check("lock_state_load", state_dbg[0], ST_LOAD);
    hold[1] = 1'b0;
    refresh();
    wait_idle(0, 300, "lock");
    exp_g.push_back(4'b0010); exp_g.push_back(4'b0100);
    check_glog(0, "lock");
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    check_rx(0, "lock");

    // Start timeout with the UART not answering
    clear_logs();
    stuck[0] = 1'b1;
    push_byte(0, 3, 8'h5A, 1'b1);
    refresh();
    repeat (60) step();
    check("to_pulses", to_cyc_q.size() >= 3, 1);
    if (to_cyc_q.size() >= 3 && tx_cyc_q.size() >= 3) begin
      check("to_period_a", to_cyc_q[1] - to_cyc_q[0], 17);
      check("to_period_b", to_cyc_q[2] - to_cyc_q[1], 17);
      check("kick_period", tx_cyc_q[2] - tx_cyc_q[1], 17);
      check("kick_after_to", tx_cyc_q[1] - to_cyc_q[0], 1);
    end
    while (txb_q.size() > 0) check("to_tx_byte", txb_q.pop_front(), 8'h5A);
    check("to_grant", grant[0], 4'b1000);
    stuck[0] = 1'b0;
    wait_idle(0, 100, "to");
    exp_q.push_back(8'h5A);
    check_rx(0, "to");

    // Inter-byte gap: chan 0 (no gap) and chan 1 (5 idle clocks)
    clear_logs();
    push_byte(0, 0, 8'h61, 1'b0);
    push_byte(0, 0, 8'h62, 1'b1);
    push_byte(1, 0, 8'h71, 1'b0);
    push_byte(1, 0, 8'h72, 1'b1);
    refresh();
    wait_idle(0, 200, "gap0");
    wait_idle(1, 200, "gap1");
    check("gap0_meas_count", gap0_q.size(), 1);
    check("gap1_meas_count", gap1_q.size(), 1);
    if (gap0_q.size() > 0) check("gap0_len", gap0_q[0], 1);
    if (gap1_q.size() > 0) check("gap1_len", gap1_q[0], 6);
    exp_q.push_back(8'h61); exp_q.push_back(8'h62);
    check_rx(0, "gap0");
    exp_q.push_back(8'h71); exp_q.push_back(8'h72);
    check_rx(1, "gap1");

    // Reset in the middle of a byte, then fresh arbitration
    clear_logs();
    push_byte(0, 1, 8'h77, 1'b1);
    refresh();
    hit = 1'b0;
    for (int n = 0; n < 40 && !hit; n++) begin
      step();
      hit = (state_dbg[0] == ST_WAIT_DONE);
    end
    check("mid_reached_wait_done", hit, 1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_grant", grant[0], 4'h0);
    check("mid_req_ready", req_ready[0], 4'h0);
    check("mid_transmit", uart_transmit[0], 1'b0);
    check("mid_tx_byte", uart_tx_byte[0], 8'h00);
    check("mid_busy", busy[0], 1'b0);
    check("mid_tx_timeout", tx_timeout[0], 1'b0);
    check("mid_state", state_dbg[0], ST_IDLE);
    apply_reset();
    push_byte(0, 1, 8'h78, 1'b1);
    push_byte(0, 0, 8'h79, 1'b1);
    refresh();
    wait_idle(0, 200, "post");
    exp_g.push_back(4'b0001); exp_g.push_back(4'b0010);
    check_glog(0, "post");
    exp_q.push_back(8'h79); exp_q.push_back(8'h78);
    check_rx(0, "post");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
